seven_seg_scan_driver: RTL and testbench
========================================

SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 50000, clock cycles each digit stays selected; legal range >= 1.
REQ-003 Parameter SEG_ACTIVE_LOW, default 0; when 1, SEG is the bitwise inverse of the active-high encoding.
REQ-004 Port clk  input  1  sole clock, all logic rising-edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port load  input  1  strobe; high for one cycle captures bcd_in.
REQ-007 Port bcd_in  input  4*NUM_DIGITS  packed BCD nibbles; nibble i = bcd_in[4i+3:4i]; digit 0 is least significant.
REQ-008 Port SEG  output  7  segments {g,f,e,d,c,b,a}, bit0 = a, registered.
REQ-009 Port AN  output  NUM_DIGITS  one-hot active-low digit enable, registered.

Function
REQ-010 Hold register latch[4*NUM_DIGITS-1:0] SHALL load bcd_in on each edge where load=1 and otherwise hold.
REQ-011 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; width $clog2(REFRESH_DIV), minimum 1 bit.
REQ-012 Digit index SHALL advance by 1 on each edge where prescaler = REFRESH_DIV-1; NUM_DIGITS-1 wraps to 0; REFRESH_DIV=1 advances every cycle.
REQ-013 SEG and AN SHALL be registered from the index and latch values held before the edge: one cycle latency from index change or load to output.
REQ-014 Load and index advance on the same edge SHALL both take effect; the next edge's outputs use the new index and new latch together.
REQ-015 AN SHALL have exactly one bit low (bit = index) in every cycle outside reset.
REQ-016 Active-high encoding: 0=7'h3F 1=7'h06 2=7'h5B 3=7'h4F 4=7'h66 5=7'h6D 6=7'h7D 7=7'h07 8=7'h7F 9=7'h6F.
REQ-017 Nibble values 10..15 SHALL produce blank (active-high 7'h00) for that digit; no error flag.
REQ-018 load held high for several cycles SHALL recapture bcd_in on every such edge.

Reset
REQ-019 While reset=1, on each edge: prescaler=0, index=0, latch=0, AN=all ones, SEG=blank (7'h00, or 7'h7F if SEG_ACTIVE_LOW).
REQ-020 Reset SHALL take priority over load and index advance.
REQ-021 Reset asserted mid-scan SHALL restart the scan at digit 0 with a full REFRESH_DIV dwell.
REQ-022 First edge with reset=0 SHALL produce AN with bit 0 low and SEG=encode(0)=7'h3F (active-high).

Configuration
REQ-023 Macro SEVEN_SEG_LEADING_ZERO_BLANK_EN defined: digit i>0 SHALL show blank when its nibble and all higher nibbles are 0; digit 0 is never blanked; AN scanning is unchanged.
REQ-024 Macro not defined: every digit SHALL display its encoded nibble, including leading zeros.

Structure
REQ-025 Package seven_seg_pkg SHALL hold the ten digit segment constants, SEG_BLANK, and the SEG width constant.
REQ-026 Combinational sub-module bcd_seg_encode (4-bit in, 7-bit active-high out) SHALL perform the decoding; polarity inversion and blanking stay in the top.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, SEG_ACTIVE_LOW=0)
REQ-027 Reset high 3 cycles -> AN=4'b1111, SEG=7'h00; first edge after release -> AN=4'b1110, SEG=7'h3F.
REQ-028 Load 16'h1369 -> SEG 7'h6F,7'h7D,7'h4F,7'h06 with AN 1110,1101,1011,0111, each held 4 cycles, then wraps to 1110.
REQ-029 Change bcd_in to 16'h5555 with load=0 -> displayed digits stay 9,6,3,1 for a full scan.
REQ-030 Load 16'h00A7 -> digit1 SEG=7'h00 while AN=1101; digit0 SEG=7'h07.
REQ-031 Macro defined, load 16'h0042 -> digits 3 and 2 SEG=7'h00 while AN still cycles; load 16'h0000 -> digit0 SEG=7'h3F, others blank; macro undefined -> 7'h3F on all digits.
REQ-032 Reset pulsed while AN=1011 -> next edge AN=1111; after release AN=1110 held exactly 4 cycles.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver: segment width,
// active-high glyphs for the decimal digits and the blank pattern.
// Segment bit order is {g,f,e,d,c,b,a}, bit 0 = a.
package seven_seg_pkg;

    localparam int SEG_W = 7;

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_DIGIT_0 = 7'h3F;
    localparam seg_t SEG_DIGIT_1 = 7'h06;
    localparam seg_t SEG_DIGIT_2 = 7'h5B;
    localparam seg_t SEG_DIGIT_3 = 7'h4F;
    localparam seg_t SEG_DIGIT_4 = 7'h66;
    localparam seg_t SEG_DIGIT_5 = 7'h6D;
    localparam seg_t SEG_DIGIT_6 = 7'h7D;
    localparam seg_t SEG_DIGIT_7 = 7'h07;
    localparam seg_t SEG_DIGIT_8 = 7'h7F;
    localparam seg_t SEG_DIGIT_9 = 7'h6F;
    localparam seg_t SEG_BLANK   = 7'h00;

endpackage

// File: rtl/bcd_seg_encode.sv
// Combinational BCD to seven-segment decoder, active-high output.
// Non-decimal nibbles (10..15) decode to a blank digit.
module bcd_seg_encode
    import seven_seg_pkg::*;
(
    input  logic [3:0]       bcd,
    output logic [SEG_W-1:0] seg
);

    // Map each nibble value to its glyph; anything outside 0..9 is dark
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_DIGIT_0;
            4'd1:    seg = SEG_DIGIT_1;
            4'd2:    seg = SEG_DIGIT_2;
            4'd3:    seg = SEG_DIGIT_3;
            4'd4:    seg = SEG_DIGIT_4;
            4'd5:    seg = SEG_DIGIT_5;
            4'd6:    seg = SEG_DIGIT_6;
            4'd7:    seg = SEG_DIGIT_7;
            4'd8:    seg = SEG_DIGIT_8;
            4'd9:    seg = SEG_DIGIT_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment display driver. Captures a packed BCD word on
// load, then scans one digit at a time, each digit held for REFRESH_DIV
// clocks. SEG and AN are registered, one cycle behind index/latch.
// Optional macro SEVEN_SEG_LEADING_ZERO_BLANK_EN: blank leading zero digits
// (digit 0 always shown); AN scanning is unaffected.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic [SEG_W-1:0]        SEG,
    output logic [NUM_DIGITS-1:0]   AN
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] INDEX_LAST = IW'(NUM_DIGITS - 1);
    localparam seg_t          SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;

    logic [PW-1:0]           prescaler;
    logic [IW-1:0]           index;
    logic [4*NUM_DIGITS-1:0] latch;

    logic [3:0]              cur_nibble;
    logic                    blank_lead;
    seg_t                    enc_seg;
    seg_t                    shown_seg;
    seg_t                    seg_next;
    logic [NUM_DIGITS-1:0]   an_next;
    logic                    dwell_done;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    logic                    upper_zero;
`endif

    assign dwell_done = (prescaler == PRESC_LAST);

    // Pick the nibble of the selected digit and decide leading-zero blanking
    always_comb begin
        cur_nibble = 4'd0;
        blank_lead = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IW'(i) == index) begin
                cur_nibble = latch[4*i +: 4];
            end
        end
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((IW'(i) >= index) && (latch[4*i +: 4] != 4'd0)) begin
                upper_zero = 1'b0;
            end
        end
        blank_lead = (index != '0) && upper_zero;
`endif
    end

    bcd_seg_encode u_encode (
        .bcd (cur_nibble),
        .seg (enc_seg)
    );

    // Apply blanking and output polarity, and build the one-hot-low enable
    always_comb begin
        shown_seg = blank_lead ? SEG_BLANK : enc_seg;
        seg_next  = (SEG_ACTIVE_LOW != 0) ? ~shown_seg : shown_seg;
        an_next   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_next[i] = (IW'(i) != index);
        end
    end

    // Prescaler, digit index, hold register and output registers; reset wins
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            index     <= '0;
            latch     <= '0;
            AN        <= '1;
            SEG       <= SEG_OFF;
        end else begin
            if (load) begin
                latch <= bcd_in;
            end
            prescaler <= dwell_done ? '0 : prescaler + 1'b1;
            if (dwell_done) begin
                index <= (index == INDEX_LAST) ? '0 : index + 1'b1;
            end
            AN  <= an_next;
            SEG <= seg_next;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver (4 digits, dwell 4 clocks).
// Stimulus pushes the expected SEG/AN for each edge into a queue; a monitor
// pops and compares one entry per clock after the edge.
module tb_seven_seg_scan_driver;

    localparam int ND = 4;
    localparam int RD = 4;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        int         cyc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] bcd_in;
    logic [6:0]  SEG;
    logic [3:0]  AN;

    int          total;
    int          bad;
    int          stimCount;
    int          sinceRelease;
    logic [15:0] modelLatch;
    exp_t        expQ[$];

    seven_seg_scan_driver #(
        .NUM_DIGITS     (ND),
        .REFRESH_DIV    (RD),
        .SEG_ACTIVE_LOW (0)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .bcd_in (bcd_in),
        .SEG    (SEG),
        .AN     (AN)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Glyph table straight from the display datasheet values
    function automatic logic [6:0] modelEncode(input logic [3:0] n);
        logic [6:0] tab [10];
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (n > 4'd9) return 7'h00;
        return tab[n];
    endfunction

    task automatic checkOutput(input string name, input int cyc,
                               input logic [6:0] got, input logic [6:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    // Drive one clock of inputs and predict what the registered outputs show after that edge
    task automatic applyStimulus(input logic r, input logic ld, input logic [15:0] d);
        exp_t       e;
        int         digit;
        logic [3:0] oneHot;
        logic [3:0] nib;
        @(negedge clk);
        reset  = r;
        load   = ld;
        bcd_in = d;
        if (r) begin
            e.an         = 4'hF;
            e.seg        = 7'h00;
            sinceRelease = 0;
            modelLatch   = 16'h0000;
        end else begin
            digit  = (sinceRelease / RD) % ND;
            oneHot = 4'(1 << digit);
            e.an   = ~oneHot;
            nib    = 4'(modelLatch >> (4 * digit));
            e.seg  = modelEncode(nib);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
            if (digit > 0 && (modelLatch >> (4 * digit)) == 16'h0000) e.seg = 7'h00;
`endif
            sinceRelease++;
            if (ld) modelLatch = d;
        end
        e.cyc = stimCount;
        stimCount++;
        expQ.push_back(e);
    endtask

    // Monitor: one expected entry per edge, compared just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("an", e.cyc, {3'b000, AN}, {3'b000, e.an});
                checkOutput("seg", e.cyc, SEG, e.seg);
            end
        end
    end

    initial begin
        total        = 0;
        bad          = 0;
        stimCount    = 0;
        sinceRelease = 0;
        modelLatch   = 16'h0000;
        reset        = 1'b1;
        load         = 1'b0;
        bcd_in       = 16'h0000;

        $display("[TB] reset and directed patterns");
        repeat (3) applyStimulus(1'b1, 1'b0, 16'h0000);
        repeat (3) applyStimulus(1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b1, 16'h1369);
        repeat (20) applyStimulus(1'b0, 1'b0, 16'h1369);
        repeat (17) applyStimulus(1'b0, 1'b0, 16'h5555);
        applyStimulus(1'b0, 1'b1, 16'h00A7);
        repeat (16) applyStimulus(1'b0, 1'b0, 16'h00A7);
        applyStimulus(1'b0, 1'b1, 16'h0042);
        repeat (16) applyStimulus(1'b0, 1'b0, 16'h0042);
        applyStimulus(1'b0, 1'b1, 16'h0000);
        repeat (16) applyStimulus(1'b0, 1'b0, 16'h0000);

        $display("[TB] mid-scan reset");
        applyStimulus(1'b0, 1'b1, 16'h8024);
        repeat (9) applyStimulus(1'b0, 1'b0, 16'h8024);
        applyStimulus(1'b1, 1'b1, 16'h4321);
        repeat (10) applyStimulus(1'b0, 1'b0, 16'h4321);

        $display("[TB] load held high");
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 16'(16'h1111 * (i + 1)));
        repeat (16) applyStimulus(1'b0, 1'b0, 16'hFFFF);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            if ($urandom_range(0, 3) == 0) d = d & 16'h00FF;
            applyStimulus(($urandom_range(0, 60) == 0), ($urandom_range(0, 7) == 0), d);
        end

        @(negedge clk);
        @(negedge clk);
        checkOutput("drain", stimCount, 7'(expQ.size()), 7'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
